// File: rtl/rc4_key_search_ctrl_pkg.sv
// Shared types, constants and helpers for the RC4 key search sequencer.
// Holds the sequencer state set, S RAM owner select and printable-char test.
package rc4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENG_RST,
    INIT,
    SHUF,
    DEC,
    NEXT_KEY,
    FOUND,
    FAIL
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    INIT_OWN,
    SHUF_OWN,
    DEC_OWN
  } owner_e;

  localparam logic [7:0] CHAR_A  = 8'h61;
  localparam logic [7:0] CHAR_Z  = 8'h7A;
  localparam logic [7:0] CHAR_SP = 8'h20;

  // Lower-case letters and space are the only plaintext we accept.
  function automatic logic is_valid_char(input logic [7:0] c);
    return ((c >= CHAR_A) && (c <= CHAR_Z)) || (c == CHAR_SP);
  endfunction

endpackage

// File: rtl/rc4_key_search_ctrl_if.sv
// Single-port S RAM write/address bus driven by the key search sequencer.
// The master side owns the port; the RAM (or a monitor) is the slave.
interface rc4_key_search_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_wren;

  modport master (
    output s_addr,
    output s_data,
    output s_wren
  );

  modport slave (
    input s_addr,
    input s_data,
    input s_wren
  );

endinterface

// File: rtl/rc4_key_search_ctrl_s_ram_arbiter.sv
// Combinational 3:1 mux giving the S RAM port to exactly one engine.
// With no owner the port is parked at address 0 with writes disabled.
module s_ram_arbiter
  import rc4_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  owner_e                own,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0] init_data,
  input  logic                  init_wren,
  input  logic [ADDR_WIDTH-1:0] shuf_addr,
  input  logic [DATA_WIDTH-1:0] shuf_data,
  input  logic                  shuf_wren,
  input  logic [ADDR_WIDTH-1:0] dec_addr,
  input  logic [DATA_WIDTH-1:0] dec_data,
  input  logic                  dec_wren,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_wren
);

  // Select the owning engine's bus; everything else is masked off.
  always_comb begin
    s_addr = '0;
    s_data = '0;
    s_wren = 1'b0;
    unique case (own)
      INIT_OWN: begin
        s_addr = init_addr;
        s_data = init_data;
        s_wren = init_wren;
      end
      SHUF_OWN: begin
        s_addr = shuf_addr;
        s_data = shuf_data;
        s_wren = shuf_wren;
      end
      DEC_OWN: begin
        s_addr = dec_addr;
        s_data = dec_data;
        s_wren = dec_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// RC4 brute-force key search sequencer: init -> shuffle -> decrypt per key.
// Build option RC4_EARLY_ABORT_EN: reject a key on the first bad byte.
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int                   KEY_WIDTH   = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX     = 24'h3F_FFFF,
  parameter int                   MESSAGE_LEN = 32,
  parameter int                   ADDR_WIDTH  = 8,
  parameter int                   DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [KEY_WIDTH-1:0]  key,
  output logic                  eng_rst,
  output logic                  init_start,
  output logic                  shuf_start,
  output logic                  dec_start,
  input  logic                  init_finish,
  input  logic                  shuf_finish,
  input  logic                  dec_finish,
  input  logic [ADDR_WIDTH-1:0] init_s_addr,
  input  logic [ADDR_WIDTH-1:0] shuf_s_addr,
  input  logic [ADDR_WIDTH-1:0] dec_s_addr,
  input  logic [DATA_WIDTH-1:0] init_s_data,
  input  logic [DATA_WIDTH-1:0] shuf_s_data,
  input  logic [DATA_WIDTH-1:0] dec_s_data,
  input  logic                  init_s_wren,
  input  logic                  shuf_s_wren,
  input  logic                  dec_s_wren,
  rc4_key_search_ctrl_if.master s_ram,
  input  logic                  dec_result_wren,
  input  logic [DATA_WIDTH-1:0] dec_result_data,
  output logic                  busy,
  output logic                  found,
  output logic                  exhausted
);

  localparam int CW = $clog2(MESSAGE_LEN + 1);
  localparam logic [CW-1:0] MSG_LEN = CW'(MESSAGE_LEN);

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 first_q, first_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 chk_byte;
  logic                 bad_now;
  owner_e               own;
  logic [ADDR_WIDTH-1:0] arb_addr;
  logic [DATA_WIDTH-1:0] arb_data;
  logic                  arb_wren;

`ifndef RC4_EARLY_ABORT_EN
  logic                 bad_q, bad_d;
`endif

  // Only the first MESSAGE_LEN result bytes of a run are plaintext.
  assign chk_byte = (state_q == DEC) && dec_result_wren
                    && (cnt_q < MSG_LEN);
  assign bad_now  = chk_byte
                    && !is_valid_char(dec_result_data[7:0]);

  // Next-state, key stepping and per-key bookkeeping.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
`ifndef RC4_EARLY_ABORT_EN
    bad_d   = bad_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ENG_RST;
          key_d   = '0;
        end
      end
      ENG_RST: begin
        cnt_d   = '0;
`ifndef RC4_EARLY_ABORT_EN
        bad_d   = 1'b0;
`endif
        state_d = INIT;
      end
      INIT: begin
        if (!first_q && init_finish) state_d = SHUF;
      end
      SHUF: begin
        if (!first_q && shuf_finish) state_d = DEC;
      end
      DEC: begin
        if (chk_byte) cnt_d = cnt_q + CW'(1);
`ifdef RC4_EARLY_ABORT_EN
        if (bad_now) begin
          state_d = NEXT_KEY;
        end else if (!first_q && dec_finish) begin
          state_d = FOUND;
        end
`else
        if (bad_now) bad_d = 1'b1;
        if (!first_q && dec_finish) begin
          state_d = (bad_q || bad_now) ? NEXT_KEY : FOUND;
        end
`endif
      end
      NEXT_KEY: begin
        if (key_q == KEY_MAX) begin
          state_d = FAIL;
        end else begin
          key_d   = key_q + KEY_WIDTH'(1);
          state_d = ENG_RST;
        end
      end
      FOUND: ;
      FAIL: ;
      default: state_d = IDLE;
    endcase
    first_d = (state_d != state_q);
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      first_q <= 1'b0;
      cnt_q   <= '0;
`ifndef RC4_EARLY_ABORT_EN
      bad_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
`ifndef RC4_EARLY_ABORT_EN
      bad_q   <= bad_d;
`endif
    end
  end

  // S RAM owner follows the engine whose state we are in.
  always_comb begin
    own = NONE;
    unique case (state_q)
      INIT:    own = INIT_OWN;
      SHUF:    own = SHUF_OWN;
      DEC:     own = DEC_OWN;
      default: own = NONE;
    endcase
  end

  s_ram_arbiter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_arb (
    .own       (own),
    .init_addr (init_s_addr),
    .init_data (init_s_data),
    .init_wren (init_s_wren),
    .shuf_addr (shuf_s_addr),
    .shuf_data (shuf_s_data),
    .shuf_wren (shuf_s_wren),
    .dec_addr  (dec_s_addr),
    .dec_data  (dec_s_data),
    .dec_wren  (dec_s_wren),
    .s_addr    (arb_addr),
    .s_data    (arb_data),
    .s_wren    (arb_wren)
  );

  assign s_ram.s_addr = arb_addr;
  assign s_ram.s_data = arb_data;
  assign s_ram.s_wren = arb_wren;

  assign key        = key_q;
  assign eng_rst    = (state_q == ENG_RST);
  assign init_start = (state_q == INIT) && first_q;
  assign shuf_start = (state_q == SHUF) && first_q;
  assign dec_start  = (state_q == DEC)  && first_q;
  assign found      = (state_q == FOUND);
  assign exhausted  = (state_q == FAIL);
  assign busy       = !((state_q == IDLE) || found || exhausted);

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl with simple engine models.
// Engines finish 5 cycles after start; decrypter writes 32 bytes.
module tb_rc4_key_search_ctrl;
  import rc4_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] key;
  logic        eng_rst, init_start, shuf_start, dec_start;
  logic        init_finish, shuf_finish, dec_finish;
  logic [7:0]  init_s_addr, shuf_s_addr, dec_s_addr;
  logic [7:0]  init_s_data, shuf_s_data, dec_s_data;
  logic        init_s_wren, shuf_s_wren, dec_s_wren;
  logic        dec_result_wren;
  logic [7:0]  dec_result_data;
  logic        busy, found, exhausted;

  rc4_key_search_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) s_ram ();

  rc4_key_search_ctrl #(
    .KEY_WIDTH   (24),
    .KEY_MAX     (24'd7),
    .MESSAGE_LEN (32),
    .ADDR_WIDTH  (8),
    .DATA_WIDTH  (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .key             (key),
    .eng_rst         (eng_rst),
    .init_start      (init_start),
    .shuf_start      (shuf_start),
    .dec_start       (dec_start),
    .init_finish     (init_finish),
    .shuf_finish     (shuf_finish),
    .dec_finish      (dec_finish),
    .init_s_addr     (init_s_addr),
    .shuf_s_addr     (shuf_s_addr),
    .dec_s_addr      (dec_s_addr),
    .init_s_data     (init_s_data),
    .shuf_s_data     (shuf_s_data),
    .dec_s_data      (dec_s_data),
    .init_s_wren     (init_s_wren),
    .shuf_s_wren     (shuf_s_wren),
    .dec_s_wren      (dec_s_wren),
    .s_ram           (s_ram),
    .dec_result_wren (dec_result_wren),
    .dec_result_data (dec_result_data),
    .busy            (busy),
    .found           (found),
    .exhausted       (exhausted)
  );

  always #5 clk = ~clk;

  // Every engine drives a distinct constant write on its bus.
  assign init_s_addr = 8'h11;
  assign init_s_data = 8'hA1;
  assign init_s_wren = 1'b1;
  assign shuf_s_addr = 8'h22;
  assign shuf_s_data = 8'hB2;
  assign shuf_s_wren = 1'b1;
  assign dec_s_addr  = 8'h33;
  assign dec_s_data  = 8'hC3;
  assign dec_s_wren  = 1'b1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Per-key decrypter behaviour.
  logic [7:0] bad_val [8];
  int         bad_pos [8];
  logic       bad_en  [8];

  function automatic logic [7:0] byte_for(input logic [2:0] k,
                                          input int p);
    if (bad_en[k] && (p == bad_pos[k])) return bad_val[k];
    case (p % 3)
      0:       return 8'h61;
      1:       return 8'h7A;
      default: return 8'h20;
    endcase
  endfunction

  logic [3:0] icnt, scnt;
  logic [5:0] dcnt;

  always @(posedge clk) begin
    if (rst || eng_rst) begin
      icnt <= 0;
      init_finish <= 1'b0;
    end else if (init_start) begin
      icnt <= 4'd5;
    end else if (icnt != 0) begin
      icnt <= icnt - 1;
      if (icnt == 1) init_finish <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst || eng_rst) begin
      scnt <= 0;
      shuf_finish <= 1'b0;
    end else if (shuf_start) begin
      scnt <= 4'd5;
    end else if (scnt != 0) begin
      scnt <= scnt - 1;
      if (scnt == 1) shuf_finish <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst || eng_rst) begin
      dcnt <= 0;
      dec_finish <= 1'b0;
      dec_result_wren <= 1'b0;
      dec_result_data <= 8'h00;
    end else if (dec_start) begin
      dcnt <= 6'd32;
      dec_result_wren <= 1'b0;
    end else if (dcnt != 0) begin
      dec_result_wren <= 1'b1;
      dec_result_data <= byte_for(key[2:0], 32 - int'(dcnt));
      dcnt <= dcnt - 1;
      if (dcnt == 1) dec_finish <= 1'b1;
    end else begin
      dec_result_wren <= 1'b0;
    end
  end

  // Event counters.
  int   n_erst = 0, n_is = 0, n_ss = 0, n_ds = 0, n_dfin = 0;
  logic fin_prev = 1'b0;

  always @(posedge clk) begin
    fin_prev <= dec_finish;
    if (eng_rst)    n_erst <= n_erst + 1;
    if (init_start) n_is   <= n_is + 1;
    if (shuf_start) n_ss   <= n_ss + 1;
    if (dec_start)  n_ds   <= n_ds + 1;
    if (dec_finish && !fin_prev) n_dfin <= n_dfin + 1;
  end

  // Port ownership, first occurrence of each state.
  logic arb_on = 1'b0;
  logic seen [5];

  always @(negedge clk) begin
    if (!arb_on) begin
      for (int i = 0; i < 5; i++) seen[i] = 1'b0;
    end else begin
      case (dut.state_q)
        INIT: if (!seen[0]) begin
          seen[0] = 1'b1;
          check("arb_init", {s_ram.s_wren, s_ram.s_addr, s_ram.s_data},
                {1'b1, 8'h11, 8'hA1});
        end
        SHUF: if (!seen[1]) begin
          seen[1] = 1'b1;
          check("arb_shuf", {s_ram.s_wren, s_ram.s_addr, s_ram.s_data},
                {1'b1, 8'h22, 8'hB2});
        end
        DEC: if (!seen[2]) begin
          seen[2] = 1'b1;
          check("arb_dec", {s_ram.s_wren, s_ram.s_addr, s_ram.s_data},
                {1'b1, 8'h33, 8'hC3});
        end
        ENG_RST: if (!seen[3]) begin
          seen[3] = 1'b1;
          check("arb_engrst", {s_ram.s_wren, s_ram.s_addr, s_ram.s_data},
                17'd0);
        end
        NEXT_KEY: if (!seen[4]) begin
          seen[4] = 1'b1;
          check("arb_nextkey", {s_ram.s_wren, s_ram.s_addr, s_ram.s_data},
                17'd0);
        end
        default: ;
      endcase
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_all(input logic en, input logic [7:0] v, input int p);
    for (int k = 0; k < 8; k++) begin
      bad_en[k]  = en;
      bad_val[k] = v;
      bad_pos[k] = p;
    end
  endtask

  task automatic run_search(input string tag, input int budget);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (found || exhausted) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check({tag, "_timeout"}, 0, 1);
  endtask

  int   e0, i0, s0, d0, f0;
  logic hold_ok;
  bit   hit;

  initial begin
    set_all(1'b0, 8'h00, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_key", key, 0);
    check("rst_flags", {busy, found, exhausted, eng_rst}, 0);
    check("rst_starts", {init_start, shuf_start, dec_start}, 0);
    check("rst_sram", {s_ram.s_wren, s_ram.s_addr, s_ram.s_data}, 0);
    #1 rst = 1'b0;

    // T1: key 0 decrypts to valid text.
    e0 = n_erst; i0 = n_is; s0 = n_ss; d0 = n_ds;
    run_search("t1", 2000);
    check("t1_found", {found, exhausted, busy}, 3'b100);
    check("t1_key", key, 0);
    check("t1_pulses", {8'(n_erst - e0), 8'(n_is - i0),
                        8'(n_ss - s0), 8'(n_ds - d0)}, 32'h01010101);

    // T2: keys 0..2 rejected by boundary bytes, key 3 accepted.
    do_reset();
    set_all(1'b0, 8'h00, 0);
    bad_en[0] = 1'b1; bad_val[0] = 8'h1F; bad_pos[0] = 31;
    bad_en[1] = 1'b1; bad_val[1] = 8'h60; bad_pos[1] = 0;
    bad_en[2] = 1'b1; bad_val[2] = 8'h7B; bad_pos[2] = 10;
    e0 = n_erst; d0 = n_ds; f0 = n_dfin;
    arb_on = 1'b1;
    run_search("t2", 3000);
    arb_on = 1'b0;
    check("t2_found", {found, exhausted}, 2'b10);
    check("t2_key", key, 3);
    check("t2_engrst", n_erst - e0, 4);
    check("t2_decstart", n_ds - d0, 4);
`ifdef RC4_EARLY_ABORT_EN
    check("t2_decfin", n_dfin - f0, 2);
`else
    check("t2_decfin", n_dfin - f0, 4);
`endif

    // T3: every key rejected, search exhausts at KEY_MAX.
    do_reset();
    set_all(1'b1, 8'h00, 5);
    e0 = n_erst;
    run_search("t3", 4000);
    check("t3_exh", {found, exhausted, busy}, 3'b010);
    check("t3_key", key, 7);
    check("t3_engrst", n_erst - e0, 8);
    hold_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      start = (i % 4) == 0;
      @(negedge clk);
      if (!exhausted || busy || found || key != 24'd7) hold_ok = 1'b0;
    end
    start = 1'b0;
    check("t3_hold", hold_ok, 1);
    check("t3_hold_engrst", n_erst - e0, 8);

    // T4: reset in the middle of SHUF at key 7.
    do_reset();
    set_all(1'b1, 8'h7B, 3);
    bad_en[7] = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (shuf_start && key == 24'd7) begin
        hit = 1'b1;
        break;
      end
    end
    check("t4_reach_key7", hit, 1);
    @(negedge clk);
    check("t4_in_shuf", {busy, s_ram.s_addr}, {1'b1, 8'h22});
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_key", key, 0);
    check("t4_rst_flags", {busy, found, exhausted, s_ram.s_wren}, 0);
    #1 rst = 1'b0;
    set_all(1'b0, 8'h00, 0);
    e0 = n_erst;
    run_search("t4r", 2000);
    check("t4_restart", {found, key[7:0]}, {1'b1, 8'h00});
    check("t4_restart_engrst", n_erst - e0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
